// File: rtl/ace_arb_pkg.sv
// Shared types for the ACE request arbiter: request encodings and arbiter FSM states.
package ace_arb_pkg;

  typedef enum logic [1:0] {
    REQ_READ    = 2'b00,
    REQ_WRITE   = 2'b01,
    REQ_INVALID = 2'b10,
    REQ_RSVD    = 2'b11
  } req_type_t;

  typedef enum logic [1:0] {
    ARB  = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/ace_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  int j;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps non-power-of-2 requester counts correct.
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_valid && valid[j]) begin
        any_valid = 1'b1;
        idx       = IDX_W'(j);
        grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ace_req_arbiter.sv
// Round-robin arbiter sharing one ACE master controller between NUM_REQ cache-side requesters,
// holding the selected request level until ace_ready_i and forcing a one-cycle idle gap after.
module ace_req_arbiter
  import ace_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [2*NUM_REQ-1:0]      req_type_i,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic                      req_err_o,
  output logic                      read_req_o,
  output logic                      write_req_o,
  output logic                      invalid_req_o,
  input  logic                      ace_ready_i,
  output logic [ADDR_W-1:0]         ace_addr_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [WD_W-1:0] WD_MAX = '1;

  arb_state_t          state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  req_type_t           sel_type;
  logic [ADDR_W-1:0]   sel_addr;
  logic                handshake;
  req_type_t           type_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WD_W-1:0]     wd_cnt;
  logic                timeout_q;
  logic [2:0]          ace_req_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .valid     (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any_valid (arb_any)
  );

  always_comb begin
    sel_type = REQ_READ;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_type = req_type_t'(req_type_i[2*i +: 2]);
        sel_addr = req_addr_i[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Handshake: a requester holds valid (with stable type/addr) until it sees ready; the
  // transfer happens on the clock edge where valid and ready are both high. Ready is
  // one-hot and only ever offered in ARB.
  assign req_ready_o = (state == ARB) ? arb_grant : '0;
  assign handshake   = (state == ARB) && arb_any;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (arb_any) state_nxt = (sel_type == REQ_RSVD) ? GAP : BUSY;
      BUSY:    if (ace_ready_i) state_nxt = GAP;
      GAP:     state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_ptr    <= '0;
      type_q    <= REQ_READ;
      addr_q    <= '0;
      idx_q     <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
      ace_req_q <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        type_q <= sel_type;
        addr_q <= sel_addr;
        idx_q  <= arb_idx;
        rr_ptr <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        wd_cnt <= '0;
        case (sel_type)
          REQ_READ:    ace_req_q <= 3'b001;
          REQ_WRITE:   ace_req_q <= 3'b010;
          REQ_INVALID: ace_req_q <= 3'b100;
          default:     ace_req_q <= 3'b000;
        endcase
      end
      if (state == BUSY) begin
        // Dropping the level on the completion edge lets the controller re-enter IDLE clean.
        if (ace_ready_i) ace_req_q <= '0;
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        if (TIMEOUT_CYCLES != 0 && (int'(wd_cnt) + 1) >= TIMEOUT_CYCLES) timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    req_done_o = '0;
    if (state == GAP) req_done_o[idx_q] = 1'b1;
  end

  assign req_err_o     = (state == GAP) && (type_q == REQ_RSVD);
  assign read_req_o    = ace_req_q[0];
  assign write_req_o   = ace_req_q[1];
  assign invalid_req_o = ace_req_q[2];
  assign ace_addr_o    = addr_q;
  assign grant_idx_o   = idx_q;
  assign busy_o        = (state == BUSY);
  assign timeout_o     = timeout_q;

endmodule
